// File: rtl/phase_arbiter_pkg.sv
// phase_arbiter_pkg
//   Shared constants for the phase-unit arbiter: requester IDs and the tag
//   width that the tag FIFO stores.
package phase_arbiter_pkg;

    localparam int TAG_W = 1;

    // Requester IDs, also used as the tags stored in the tag FIFO.
    localparam logic [TAG_W-1:0] REQ_SHORT = 1'b0;
    localparam logic [TAG_W-1:0] REQ_LONG  = 1'b1;

endpackage

// File: rtl/phase_arbiter_tag_fifo.sv
// phase_tag_fifo
//   Synchronous FIFO of DEPTH tag entries. It records which requester issued
//   each request that is in flight in the phase unit. A push and a pop in the
//   same cycle are both performed. A push while full or a pop while empty is
//   ignored. While enable is low the FIFO is frozen.
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   enable            advance state only when high
//   push, push_tag    write a tag
//   pop, pop_tag      remove the head tag (pop_tag shows the head)
//   full, empty       occupancy flags
module phase_tag_fifo
    import phase_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] pop_tag,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = enable && push && !full;
    assign do_pop  = enable && pop && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_tag = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
    end

endmodule

// File: rtl/phase_arbiter.sv
// phase_arbiter
//   Shares one phase (atan) unit between sync_short (requester 0) and
//   sync_long (requester 1). Each requester's I/Q strobe is captured into a
//   pending register. At most one pending request is issued per cycle, using
//   round-robin arbitration. A tag FIFO records the issue order so that each
//   in-order result is routed back to the requester that issued it.
//   Results are ignored for FLUSH_CYCLES enabled cycles after reset. This
//   discards results that were still in the phase unit when reset was applied.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   enable                       freezes all state and suppresses strobes when low
//   req{0,1}_i/_q/_stb           requester I/Q and strobe
//   phase_in_i/_q/_stb           request to the phase unit
//   phase_out/_stb               in-order result from the phase unit
//   phase{0,1}_out/_stb          routed results
//   overflow[1:0]                sticky: a pending request was overwritten
//   orphan                       sticky: a result arrived with no tag queued
// Build option:
//   PHASE_ARB_STATS_EN adds the grant0_count, grant1_count and drop_count
//   outputs.
module phase_arbiter
    import phase_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH    = 8,
    parameter int FLUSH_CYCLES = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] req0_i,
    input  logic [31:0] req0_q,
    input  logic        req0_stb,
    input  logic [31:0] req1_i,
    input  logic [31:0] req1_q,
    input  logic        req1_stb,
    output logic [31:0] phase_in_i,
    output logic [31:0] phase_in_q,
    output logic        phase_in_stb,
    input  logic [31:0] phase_out,
    input  logic        phase_out_stb,
    output logic [31:0] phase0_out,
    output logic        phase0_stb,
    output logic [31:0] phase1_out,
    output logic        phase1_stb,
    output logic [1:0]  overflow,
`ifdef PHASE_ARB_STATS_EN
    output logic [31:0] grant0_count,
    output logic [31:0] grant1_count,
    output logic [31:0] drop_count,
`endif
    output logic        orphan
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    logic [63:0]        pend0;
    logic [63:0]        pend1;
    logic [1:0]         pend_valid;
    logic [TAG_W-1:0]   last_grant;
    logic [FLUSH_W-1:0] flush_cnt;

    logic               grant0;
    logic               grant1;
    logic               fifo_full;
    logic               fifo_empty;
    logic [TAG_W-1:0]   pop_tag;
    logic               result_stb;
    logic               tag_pop;
    logic               orphan_evt;
    logic [1:0]         ovf_evt;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!fifo_full) begin
            if (pend_valid[0] && pend_valid[1]) begin
                grant0 = (last_grant == REQ_LONG);
                grant1 = (last_grant == REQ_SHORT);
            end else begin
                grant0 = pend_valid[0];
                grant1 = pend_valid[1];
            end
        end
    end

    // A new strobe on a still-pending slot loses the old data, unless that
    // slot is being issued in the same cycle.
    assign ovf_evt[0] = req0_stb && pend_valid[0] && !grant0;
    assign ovf_evt[1] = req1_stb && pend_valid[1] && !grant1;

    assign result_stb = phase_out_stb && (flush_cnt == '0);
    assign tag_pop    = result_stb && !fifo_empty;
    assign orphan_evt = result_stb && fifo_empty;

    phase_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .push     (grant0 || grant1),
        .push_tag (grant1 ? REQ_LONG : REQ_SHORT),
        .pop      (tag_pop),
        .pop_tag  (pop_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pend0        <= '0;
            pend1        <= '0;
            pend_valid   <= '0;
            last_grant   <= REQ_LONG;
            flush_cnt    <= FLUSH_W'(FLUSH_CYCLES);
            phase_in_i   <= '0;
            phase_in_q   <= '0;
            phase_in_stb <= 1'b0;
            phase0_out   <= '0;
            phase0_stb   <= 1'b0;
            phase1_out   <= '0;
            phase1_stb   <= 1'b0;
            overflow     <= '0;
            orphan       <= 1'b0;
        end else if (!enable) begin
            phase_in_stb <= 1'b0;
            phase0_stb   <= 1'b0;
            phase1_stb   <= 1'b0;
        end else begin
            phase_in_stb <= grant0 || grant1;
            if (grant0) begin
                {phase_in_i, phase_in_q} <= pend0;
                last_grant               <= REQ_SHORT;
            end else if (grant1) begin
                {phase_in_i, phase_in_q} <= pend1;
                last_grant               <= REQ_LONG;
            end

            pend_valid[0] <= req0_stb || (pend_valid[0] && !grant0);
            pend_valid[1] <= req1_stb || (pend_valid[1] && !grant1);
            if (req0_stb) pend0 <= {req0_i, req0_q};
            if (req1_stb) pend1 <= {req1_i, req1_q};

            overflow <= overflow | ovf_evt;
            orphan   <= orphan | orphan_evt;

            phase0_stb <= tag_pop && (pop_tag == REQ_SHORT);
            phase1_stb <= tag_pop && (pop_tag == REQ_LONG);
            if (tag_pop && (pop_tag == REQ_SHORT)) phase0_out <= phase_out;
            if (tag_pop && (pop_tag == REQ_LONG))  phase1_out <= phase_out;

            if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
        end
    end

`ifdef PHASE_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grant0_count <= '0;
            grant1_count <= '0;
            drop_count   <= '0;
        end else if (enable) begin
            if (grant0) grant0_count <= grant0_count + 1'b1;
            if (grant1) grant1_count <= grant1_count + 1'b1;
            drop_count <= drop_count + 32'(ovf_evt[0]) + 32'(ovf_evt[1])
                                     + 32'(orphan_evt);
        end
    end
`endif

endmodule

// File: tb/tb_phase_arbiter.sv
module tb_phase_arbiter;

    localparam int TAG_DEPTH    = 8;
    localparam int FLUSH_CYCLES = 24;
    localparam int LAT          = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] req0_i, req0_q, req1_i, req1_q;
    logic        req0_stb, req1_stb;
    logic [31:0] phase_in_i, phase_in_q;
    logic        phase_in_stb;
    logic [31:0] phase_out;
    logic        phase_out_stb;
    logic [31:0] phase0_out, phase1_out;
    logic        phase0_stb, phase1_stb;
    logic [1:0]  overflow;
    logic        orphan;
`ifdef PHASE_ARB_STATS_EN
    logic [31:0] grant0_count, grant1_count, drop_count;
`endif

    phase_arbiter #(.TAG_DEPTH(TAG_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req0_i(req0_i), .req0_q(req0_q), .req0_stb(req0_stb),
        .req1_i(req1_i), .req1_q(req1_q), .req1_stb(req1_stb),
        .phase_in_i(phase_in_i), .phase_in_q(phase_in_q), .phase_in_stb(phase_in_stb),
        .phase_out(phase_out), .phase_out_stb(phase_out_stb),
        .phase0_out(phase0_out), .phase0_stb(phase0_stb),
        .phase1_out(phase1_out), .phase1_stb(phase1_stb),
        .overflow(overflow),
`ifdef PHASE_ARB_STATS_EN
        .grant0_count(grant0_count), .grant1_count(grant1_count), .drop_count(drop_count),
`endif
        .orphan(orphan)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 0;
    bit stall  = 0;
    bit inject = 0;
    bit use_fixed = 0;

    typedef struct { logic [63:0] data; int due; } iss_t;
    typedef struct { int tag; logic [31:0] data; int due; } res_t;
    iss_t exp_iss[$];
    res_t exp_res[$];
    int   stub_q[$];

    // Reference model state: pending slots, in-flight tag order, sticky flags.
    logic [63:0] m_pend[2];
    bit          m_pv[2];
    int          m_last;
    int          m_tags[$];
    bit [1:0]    m_ovf;
    bit          m_orphan;
    int          m_flush;
    int          m_g0, m_g1, m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clock) begin
        int g;
        bit stb[2];
        logic [63:0] din[2];
        cyc++;
        stb[0] = req0_stb;
        stb[1] = req1_stb;
        din[0] = {req0_i, req0_q};
        din[1] = {req1_i, req1_q};
        if (reset) begin
            m_pv[0] = 0; m_pv[1] = 0;
            m_last = 1;
            m_tags.delete();
            m_ovf = 0; m_orphan = 0;
            m_flush = FLUSH_CYCLES;
            m_g0 = 0; m_g1 = 0; m_drop = 0;
        end else if (enable) begin
            g = -1;
            if (m_tags.size() < TAG_DEPTH) begin
                if (m_pv[0] && m_pv[1]) g = 1 - m_last;
                else if (m_pv[0]) g = 0;
                else if (m_pv[1]) g = 1;
            end
            if (g >= 0) begin
                exp_iss.push_back('{m_pend[g], cyc});
                m_last = g;
                if (g == 0) m_g0++; else m_g1++;
            end
            if (phase_out_stb && m_flush == 0) begin
                if (m_tags.size() == 0) begin
                    m_orphan = 1;
                    m_drop++;
                end else begin
                    exp_res.push_back('{m_tags.pop_front(), phase_out, cyc});
                end
            end
            if (g >= 0) m_tags.push_back(g);
            for (int n = 0; n < 2; n++) begin
                if (stb[n]) begin
                    if (m_pv[n] && g != n) begin
                        m_ovf[n] = 1;
                        m_drop++;
                    end
                    m_pend[n] = din[n];
                    m_pv[n] = 1;
                end else if (g == n) begin
                    m_pv[n] = 0;
                end
            end
            if (m_flush > 0) m_flush--;
        end
    end

    // Monitor/scoreboard, then the phase-unit stub (fixed latency, in order).
    always @(negedge clock) begin
        iss_t e;
        res_t r;
        int   tag;
        if (mon_en) begin
            if (phase_in_stb) begin
                if (exp_iss.size() == 0) flag_fail("unexpected_issue");
                else begin
                    e = exp_iss.pop_front();
                    chk("issue_data", {phase_in_i, phase_in_q}, e.data);
                    chk("issue_cycle", cyc, e.due);
                end
            end else if (exp_iss.size() > 0 && exp_iss[0].due <= cyc) begin
                void'(exp_iss.pop_front());
                flag_fail("missing_issue");
            end
            if (phase0_stb && phase1_stb) flag_fail("both_result_strobes");
            if (phase0_stb || phase1_stb) begin
                tag = phase1_stb ? 1 : 0;
                if (exp_res.size() == 0) flag_fail("unexpected_result");
                else begin
                    r = exp_res.pop_front();
                    chk("result_tag", tag, r.tag);
                    chk("result_data", tag ? phase1_out : phase0_out, r.data);
                    chk("result_cycle", cyc, r.due);
                end
            end else if (exp_res.size() > 0 && exp_res[0].due <= cyc) begin
                void'(exp_res.pop_front());
                flag_fail("missing_result");
            end
            chk("overflow", overflow, m_ovf);
            chk("orphan", orphan, m_orphan);

            if (phase_in_stb) stub_q.push_back(cyc + LAT);
            phase_out_stb = 1'b0;
            if (inject) begin
                phase_out_stb = 1'b1;
                phase_out = $urandom;
                inject = 0;
            end else if (enable && !stall && stub_q.size() > 0 && stub_q[0] <= cyc) begin
                void'(stub_q.pop_front());
                phase_out_stb = 1'b1;
                phase_out = use_fixed ? 32'h1234 : $urandom;
            end
        end
    end

    task automatic req(input bit s0, input bit s1);
        req0_stb = s0;
        req1_stb = s1;
        if (s0) begin req0_i = $urandom; req0_q = $urandom; end
        if (s1) begin req1_i = $urandom; req1_q = $urandom; end
        @(negedge clock);
        req0_stb = 0;
        req1_stb = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_iss.size() || exp_res.size() || stub_q.size()) && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) flag_fail(name);
    endtask

    initial begin
        int n;
        reset = 1; enable = 1;
        req0_i = 0; req0_q = 0; req1_i = 0; req1_q = 0;
        req0_stb = 0; req1_stb = 0;
        phase_out = 0; phase_out_stb = 0;
        @(negedge clock);
        @(negedge clock);
        mon_en = 1;
        chk("reset_phase_in", {phase_in_stb, phase_in_i, phase_in_q}, 0);
        chk("reset_results", {phase0_stb, phase0_out, phase1_stb, phase1_out}, 0);
        chk("reset_flags", {overflow, orphan}, 0);
        reset = 0;

        // Result inside the flush window is ignored; one afterwards is an orphan.
        repeat (4) @(negedge clock);
        inject = 1;
        repeat (2) @(negedge clock);
        chk("flush_no_orphan", orphan, 0);
        repeat (24) @(negedge clock);
        inject = 1;
        repeat (2) @(negedge clock);
        chk("orphan_after_flush", orphan, 1);

        // Single request: two-cycle issue latency, routed to requester 0.
        use_fixed = 1;
        req0_stb = 1; req0_i = 32'h00010000; req0_q = 0;
        @(negedge clock);
        req0_stb = 0;
        chk("lat_early", phase_in_stb, 0);
        @(negedge clock);
        chk("lat_issue", {phase_in_stb, phase_in_i, phase_in_q}, {1'b1, 32'h00010000, 32'h0});
        @(negedge clock);
        chk("lat_pulse", phase_in_stb, 0);
        n = 0;
        while (!phase0_stb && n < 60) begin @(negedge clock); n++; end
        chk("single_result", {phase0_stb, phase0_out}, {1'b1, 32'h1234});
        use_fixed = 0;
        drain("drain_single");

        // Simultaneous requests, three back to back.
        do_reset();
        repeat (3) req(1, 1);
        repeat (6) @(negedge clock);
        drain("drain_simul");

        // FIFO full: stub stalls; 9 requests, then overwrite on requester 1.
        do_reset();
        stall = 1;
        repeat (9) begin req(1, 0); @(negedge clock); end
        repeat (3) @(negedge clock);
        req(0, 1);
        req(0, 1);
        @(negedge clock);
        chk("full_overwrite", overflow, 2'b10);
        stall = 0;
        drain("drain_full");

        // Enable low with two requests in flight.
        req(1, 0);
        req(0, 1);
        repeat (5) @(negedge clock);
        stall = 1;
        @(negedge clock);
        enable = 0;
        repeat (10) begin
            @(negedge clock);
            chk("disabled_quiet", {phase_in_stb, phase0_stb, phase1_stb}, 0);
        end
        enable = 1;
        stall = 0;
        drain("drain_enable");

        // Reset with three requests in flight; late results fall in the flush window.
        req(1, 0); req(0, 1); req(1, 0);
        repeat (6) @(negedge clock);
        do_reset();
        chk("midreset_outputs", {phase_in_stb, phase0_stb, phase1_stb, phase0_out, phase1_out}, 0);
        repeat (30) @(negedge clock);
        chk("midreset_no_orphan", orphan, 0);
        drain("drain_midreset");

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                stall = 1;
                @(negedge clock);
                enable = 0;
                repeat ($urandom_range(1, 8)) @(negedge clock);
                enable = 1;
            end
            if ($urandom_range(0, 99) < 3) stall = ~stall;
            req($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35);
        end
        stall = 0;
        repeat (4) @(negedge clock);
        drain("drain_random");

`ifdef PHASE_ARB_STATS_EN
        chk("grant0_count", grant0_count, m_g0);
        chk("grant1_count", grant1_count, m_g1);
        chk("drop_count", drop_count, m_drop);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
